// File: rtl/mux_21_arbiter_if.sv
// Shared channel between two packet producers, the 2:1 arbiter and one consumer.
// master is the arbiter side; slave is the producer/consumer side.
interface mux_21_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic [1:0]       req;
   logic [WIDTH-1:0] A0;
   logic [WIDTH-1:0] A1;
   logic [1:0]       last;
   logic [1:0]       gnt;
   logic             S;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_ready;

   modport master (
      input  req, A0, A1, last, out_ready,
      output gnt, S, out_valid, out_data, out_last
   );

   modport slave (
      output req, A0, A1, last, out_ready,
      input  gnt, S, out_valid, out_data, out_last
   );
endinterface

// File: rtl/mux_21_arbiter.sv
// Two-requester packet-level round-robin arbiter driving a 2:1 data mux, with beat cap and idle abort.
// Optional per-requester completed-packet counters are enabled by defining MUX21_ARB_PKT_CNT_EN.
module mux_21_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BEATS = 16,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mux_21_arbiter_if.master bus
`ifdef MUX21_ARB_PKT_CNT_EN
   ,
   output logic [15:0]      pkt_cnt0,
   output logic [15:0]      pkt_cnt1
`endif
);

   localparam int unsigned BEAT_W = $clog2(MAX_BEATS) + 1;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_e;

   state_e              r_state;
   logic                r_s;
   logic                r_rr_ptr;
   logic [BEAT_W-1:0]   r_beat_cnt;
   logic [IDLE_W-1:0]   r_idle_cnt;

   state_e              w_state_nxt;
   logic                w_s_nxt;
   logic                w_rr_nxt;
   logic [BEAT_W-1:0]   w_beat_nxt;
   logic [IDLE_W-1:0]   w_idle_nxt;

   logic                w_owned;
   logic                w_other;
   logic                w_req_s;
   logic                w_last_s;
   logic                w_valid;
   logic                w_xfer;
   logic                w_cap;
   logic                w_release;
   logic                w_abort;
   logic [WIDTH-1:0]    w_data_sel;

   // Owner-side view of the request/handshake; S doubles as the owner index while owned.
   assign w_owned    = (r_state != ST_IDLE);
   assign w_other    = ~r_s;
   assign w_req_s    = bus.req[r_s];
   assign w_last_s   = bus.last[r_s];
   assign w_valid    = w_owned & w_req_s;
   assign w_xfer     = w_valid & bus.out_ready;
   assign w_cap      = (r_beat_cnt == BEAT_W'(MAX_BEATS - 1));
   assign w_release  = w_xfer & (w_last_s | w_cap);
   assign w_abort    = w_owned & ~w_req_s & (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
   assign w_data_sel = r_s ? bus.A1 : bus.A0;

   // Output channel is a pure mux of the owner's inputs, zeroed when no beat is offered.
   assign bus.S         = r_s;
   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_valid ? w_data_sel : '0;
   assign bus.out_last  = w_valid & w_last_s;
   assign bus.gnt       = {w_xfer & r_s, w_xfer & ~r_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_s        <= 1'b0;
         r_rr_ptr   <= 1'b0;
         r_beat_cnt <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_s        <= w_s_nxt;
         r_rr_ptr   <= w_rr_nxt;
         r_beat_cnt <= w_beat_nxt;
         r_idle_cnt <= w_idle_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_rr_nxt    = r_rr_ptr;
      w_beat_nxt  = r_beat_cnt;
      w_idle_nxt  = r_idle_cnt;

      case (r_state)
         ST_IDLE: begin
            if (bus.req != 2'b00) begin
               w_s_nxt     = (bus.req == 2'b11) ? r_rr_ptr : bus.req[1];
               w_state_nxt = w_s_nxt ? ST_OWN1 : ST_OWN0;
            end
         end

         ST_OWN0, ST_OWN1: begin
            if (w_release | w_abort) begin
               // Hand over without a bubble: the other side wins if it is waiting.
               w_rr_nxt   = w_other;
               w_beat_nxt = '0;
               w_idle_nxt = '0;
               if (bus.req[w_other]) begin
                  w_s_nxt     = w_other;
                  w_state_nxt = w_other ? ST_OWN1 : ST_OWN0;
               end else if (!w_req_s) begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               if (w_xfer) begin
                  w_beat_nxt = r_beat_cnt + BEAT_W'(1);
               end
               w_idle_nxt = w_req_s ? '0 : (r_idle_cnt + IDLE_W'(1));
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef MUX21_ARB_PKT_CNT_EN
   logic [15:0] r_pkt_cnt0;
   logic [15:0] r_pkt_cnt1;

   // Completed packets only (last- or cap-triggered); aborts never count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt0 <= '0;
         r_pkt_cnt1 <= '0;
      end else if (w_release) begin
         if (!r_s && (r_pkt_cnt0 != 16'hFFFF)) begin
            r_pkt_cnt0 <= r_pkt_cnt0 + 16'd1;
         end
         if (r_s && (r_pkt_cnt1 != 16'hFFFF)) begin
            r_pkt_cnt1 <= r_pkt_cnt1 + 16'd1;
         end
      end
   end

   assign pkt_cnt0 = r_pkt_cnt0;
   assign pkt_cnt1 = r_pkt_cnt1;
`endif

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt));

   a_sel_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.out_valid && !bus.out_ready) |=> $stable(bus.S));

endmodule

// File: doc/mux_21_arbiter.md
Name: mux_21_arbiter

Overview:
- Two-requester, packet-level round-robin arbiter.
- Owns a 2:1 data mux: drives its select, steers the winning requester's data and last onto a single shared output channel.
- Uses a valid/ready handshake with fairness, a packet-length cap and an idle-timeout abort.
- Sits between two producer blocks and one shared consumer.

Parameters:
- WIDTH, 8, data width of each requester input and of the output.
- MAX_BEATS, 16, maximum beats per grant before forced release (≥1).
- TIMEOUT, 8, consecutive cycles of granted-requester idle (req low) before abort (≥1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  req[i]: requester i has a valid beat
- A0  input  WIDTH  requester 0 data
- A1  input  WIDTH  requester 1 data
- last  input  2  last[i]: current beat of requester i ends its packet
- gnt  output  2  gnt[i]: beat of requester i accepted this cycle
- S  output  1  mux select, current owner (0 → A0, 1 → A1)
- out_valid  output  1  output beat valid
- out_data  output  WIDTH  muxed data
- out_last  output  1  muxed last
- out_ready  input  1  consumer accepts the beat

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, S = 0, rr_ptr = 0 (requester 0 preferred first).
  - beat_cnt = 0, idle_cnt = 0.
  - gnt = 2'b00, out_valid = 0, out_data = 0, out_last = 0.
- States: IDLE, OWN0, OWN1. S is a register equal to the owner; it holds its last value in IDLE.
- Output muxing and handshake:
  - out_data/out_last = S ? A1/last[1] : A0/last[0], combinational from inputs.
  - They are forced to 0 when out_valid = 0.
  - out_valid = req[S] while in OWNx; 0 in IDLE.
  - Transfer = out_valid & out_ready. gnt[S] = transfer (combinational); the other gnt bit is 0.
- IDLE:
  - Only req[0] high → OWN0. Only req[1] high → OWN1.
  - Both high → OWN(rr_ptr).
  - No output beat is offered in the IDLE cycle (one cycle grant latency).
- OWNx:
  - On each transfer, beat_cnt increments.
  - Release condition: transfer & (last[x] | beat_cnt == MAX_BEATS-1).
  - idle_cnt increments each cycle req[x] = 0 and clears when req[x] = 1.
  - Abort condition: idle_cnt == TIMEOUT-1 with req[x] still 0. Abort releases without a transfer.
- On release or abort:
  - rr_ptr ← ~x; beat_cnt ← 0; idle_cnt ← 0.
  - Next state: req[~x] → OWN(~x); else req[x] → OWNx (re-grant, new packet); else → IDLE.
- Back-to-back switch: handover takes effect the next cycle with no IDLE bubble. This is a zero-bubble handover.
- Backpressure: out_ready = 0 stalls; beat_cnt, state and S hold. idle_cnt is unaffected by out_ready.
- Stability: S never changes while out_valid = 1 and out_ready = 0 within a packet.
- Reset mid-packet: immediate return to reset values; the packet is truncated with no recovery.
- Width: beat_cnt is clog2(MAX_BEATS)+1 bits; idle_cnt is clog2(TIMEOUT)+1 bits. Neither wraps; both clear on release.

Optional Feature:
- Macro: MUX21_ARB_PKT_CNT_EN.
- Defined:
  - Adds outputs pkt_cnt0 and pkt_cnt1, 16 bits each.
  - Each counts completed releases of its requester (last- or cap-triggered; aborts excluded).
  - Saturates at 16'hFFFF. Reset value is 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with req = 2'b11 held → gnt = 0, out_valid = 0, S = 0 during reset. First cycle after release: IDLE. Next cycle: OWN0, out_data = A0.
- Both requesters continuously requesting 3-beat packets (last on beat 3), out_ready = 1 → S sequence 0,0,0,1,1,1,0,0,0. Zero-bubble switches. gnt alternates per packet.
- Requester 0 sends 20 beats with no last, MAX_BEATS = 16, req[1] = 1 → release after 16th transfer; S = 1 next cycle. Requester 0 regains ownership after requester 1's packet.
- OWN1, requester 1 drops req for 8 cycles (TIMEOUT = 8), req[0] = 1 → abort on cycle 8, OWN0 next cycle, no gnt[1] pulse during idle.
- OWN0 mid-packet, out_ready = 0 for 5 cycles with A0 = 8'h5A → out_valid = 1, out_data = 8'h5A, gnt = 0, S stable. Transfer on the cycle out_ready returns to 1.
- MUX21_ARB_PKT_CNT_EN defined: 4 completed packets from requester 0 and 1 aborted packet from requester 1 → pkt_cnt0 = 4, pkt_cnt1 = 0.
